// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flexible FIFO controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fifo_pkg;

  // Status bundle, laid out for reuse by software-visible status registers.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Increment-with-wrap for an arbitrary depth. The sum is formed at 32 bits,
  // so it is always wider than the pointer and the compare never sees a
  // truncated value.
  function automatic int ptr_wrap(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap counter for one FIFO pointer (write or read side).
// Latency: ptr updates one cycle after inc/clr.
// Backpressure: none; the caller qualifies inc.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter  int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  clr,
  output logic [ADDR_WIDTH-1:0] ptr
);

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  // Next pointer: clear wins over advance; advance wraps at DEPTH-1 so
  // non-power-of-2 depths work.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ADDR_WIDTH'(ptr_wrap(int'(ptr_q), DEPTH));
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl_flex.sv
// FIFO controller for an external dual-port SRAM: addresses, strobes, count, flags.
// Latency: w_fire/r_fire combinational; addresses, count and flags 1 cycle after fire.
// Backpressure: writes refused while full, reads refused while empty; refusals set sticky errors.
module fifo_ctrl_flex
  import fifo_pkg::*;
#(
  parameter  int DEPTH      = 8,
  parameter  int AF_LEVEL   = DEPTH - 2,
  parameter  int AE_LEVEL   = 2,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic                  w_fire,
  output logic                  r_fire,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  // Empty FIFO: count 0 is always at or below AE_LEVEL and below AF_LEVEL.
  localparam fifo_status_t STATUS_RST = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

  logic [CNT_WIDTH-1:0] count_q, count_d;
  fifo_status_t         status_q, status_d;
  logic                 ovf_set, unf_set;

  // Acceptance from registered flags only; flush and reset block both sides.
  assign w_fire = rst_n & w_en & ~status_q.full  & ~flush;
  assign r_fire = rst_n & r_en & ~status_q.empty & ~flush;

  // A request refused at a boundary is an error; a flush cycle is not.
  assign ovf_set = w_en & status_q.full  & ~flush;
  assign unf_set = r_en & status_q.empty & ~flush;

  // Next count and flags; flags decode count_d so they line up with count.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_WIDTH'(w_fire) - CNT_WIDTH'(r_fire);
    end
    status_d              = status_q;
    status_d.full         = (count_d == CNT_WIDTH'(DEPTH));
    status_d.empty        = (count_d == '0);
    status_d.almost_full  = (count_d >= CNT_WIDTH'(AF_LEVEL));
    status_d.almost_empty = (count_d <= CNT_WIDTH'(AE_LEVEL));
    // Set wins over a simultaneous clear.
    status_d.overflow     = ovf_set | (status_q.overflow  & ~clr_err);
    status_d.underflow    = unf_set | (status_q.underflow & ~clr_err);
  end

  // Count and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      status_q <= STATUS_RST;
    end else begin
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

  fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_fire),
    .clr   (flush),
    .ptr   (w_addr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (r_fire),
    .clr   (flush),
    .ptr   (r_addr)
  );

  assign count        = count_q;
  assign full         = status_q.full;
  assign empty        = status_q.empty;
  assign almost_full  = status_q.almost_full;
  assign almost_empty = status_q.almost_empty;
  assign overflow     = status_q.overflow;
  assign underflow    = status_q.underflow;

endmodule

// File: tb/tb_fifo_ctrl_flex.sv
// Bench for fifo_ctrl_flex: DEPTH=8 (AF=6, AE=2) and DEPTH=5 instances.
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_ctrl_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: DEPTH=8
  logic       a_w, a_r, a_fl, a_ce;
  logic       a_wf, a_rf, a_full, a_empty, a_af, a_ae, a_ov, a_un;
  logic [2:0] a_wa, a_ra;
  logic [3:0] a_cnt;

  // Instance B: DEPTH=5
  logic       b_w, b_r, b_fl, b_ce;
  logic       b_wf, b_rf, b_full, b_empty, b_af, b_ae, b_ov, b_un;
  logic [2:0] b_wa, b_ra;
  logic [2:0] b_cnt;

  fifo_ctrl_flex #(.DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u_a (
    .clk(clk), .rst_n(rst_n), .w_en(a_w), .r_en(a_r), .flush(a_fl), .clr_err(a_ce),
    .w_fire(a_wf), .r_fire(a_rf), .w_addr(a_wa), .r_addr(a_ra), .count(a_cnt),
    .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .overflow(a_ov), .underflow(a_un)
  );

  fifo_ctrl_flex #(.DEPTH(5)) u_b (
    .clk(clk), .rst_n(rst_n), .w_en(b_w), .r_en(b_r), .flush(b_fl), .clr_err(b_ce),
    .w_fire(b_wf), .r_fire(b_rf), .w_addr(b_wa), .r_addr(b_ra), .count(b_cnt),
    .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .overflow(b_ov), .underflow(b_un)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: occupancy, pointers as integers modulo depth, sticky errors.
  typedef struct {
    int cnt;
    int wp;
    int rp;
    bit ovf;
    bit unf;
  } ms_t;

  ms_t ma, mb;

  function automatic ms_t mreset();
    ms_t s;
    s.cnt = 0; s.wp = 0; s.rp = 0; s.ovf = 0; s.unf = 0;
    return s;
  endfunction

  function automatic ms_t mstep(input ms_t s, input int depth,
                                input bit we, input bit re, input bit fl, input bit ce);
    ms_t n;
    bit  wf, rf;
    n  = s;
    wf = we && (s.cnt < depth) && !fl;
    rf = re && (s.cnt > 0) && !fl;
    if (fl) begin
      n.cnt = 0; n.wp = 0; n.rp = 0;
    end else begin
      n.cnt = s.cnt + (wf ? 1 : 0) - (rf ? 1 : 0);
      if (wf) n.wp = (s.wp + 1) % depth;
      if (rf) n.rp = (s.rp + 1) % depth;
    end
    n.ovf = (we && (s.cnt == depth) && !fl) || (s.ovf && !ce);
    n.unf = (re && (s.cnt == 0) && !fl) || (s.unf && !ce);
    return n;
  endfunction

  task automatic cmp(input string tg, input ms_t s, input int depth, input int af, input int ae,
                     input bit we, input bit re, input bit fl,
                     input int cnt, input int wa, input int ra,
                     input bit fu, input bit em, input bit afl, input bit ael,
                     input bit ov, input bit un, input bit wf, input bit rf);
    chk({tg, ".count"},  cnt, s.cnt);
    chk({tg, ".w_addr"}, wa,  s.wp);
    chk({tg, ".r_addr"}, ra,  s.rp);
    chk({tg, ".full"},   int'(fu),  (s.cnt == depth) ? 1 : 0);
    chk({tg, ".empty"},  int'(em),  (s.cnt == 0) ? 1 : 0);
    chk({tg, ".afull"},  int'(afl), (s.cnt >= af) ? 1 : 0);
    chk({tg, ".aempty"}, int'(ael), (s.cnt <= ae) ? 1 : 0);
    chk({tg, ".ovf"},    int'(ov),  int'(s.ovf));
    chk({tg, ".unf"},    int'(un),  int'(s.unf));
    chk({tg, ".w_fire"}, int'(wf),  (rst_n && we && s.cnt < depth && !fl) ? 1 : 0);
    chk({tg, ".r_fire"}, int'(rf),  (rst_n && re && s.cnt > 0 && !fl) ? 1 : 0);
  endtask

  // Single compare process: inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      ma = mreset();
      mb = mreset();
    end
    cmp("A", ma, 8, 6, 2, a_w, a_r, a_fl, int'(a_cnt), int'(a_wa), int'(a_ra),
        a_full, a_empty, a_af, a_ae, a_ov, a_un, a_wf, a_rf);
    cmp("B", mb, 5, 3, 2, b_w, b_r, b_fl, int'(b_cnt), int'(b_wa), int'(b_ra),
        b_full, b_empty, b_af, b_ae, b_ov, b_un, b_wf, b_rf);
    if (rst_n) begin
      ma = mstep(ma, 8, a_w, a_r, a_fl, a_ce);
      mb = mstep(mb, 5, b_w, b_r, b_fl, b_ce);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic da(input bit w, input bit r, input bit fl, input bit ce);
    a_w = w; a_r = r; a_fl = fl; a_ce = ce;
  endtask

  task automatic db(input bit w, input bit r, input bit fl, input bit ce);
    b_w = w; b_r = r; b_fl = fl; b_ce = ce;
  endtask

  initial begin
    ma = mreset();
    mb = mreset();
    rst_n = 1'b0;
    da(0, 0, 0, 0);
    db(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.count", int'(a_cnt), 0);
    chk("rst.empty", int'(a_empty), 1);
    chk("rst.full",  int'(a_full), 0);
    chk("rst.ae",    int'(a_ae), 1);
    chk("rst.af",    int'(a_af), 0);
    rst_n = 1'b1;
    tick();

    // 1: eight writes, address steps and threshold crossings
    for (int i = 0; i < 8; i++) begin
      da(1, 0, 0, 0);
      #1;
      chk("t1.w_addr", int'(a_wa), i);
      chk("t1.w_fire", int'(a_wf), 1);
      tick();
      chk("t1.count", int'(a_cnt), i + 1);
      chk("t1.af", int'(a_af), (i + 1 >= 6) ? 1 : 0);
      chk("t1.ae", int'(a_ae), (i + 1 <= 2) ? 1 : 0);
    end
    chk("t1.wrap", int'(a_wa), 0);
    chk("t1.full", int'(a_full), 1);

    // 2: ninth write is refused and overflow is sticky until cleared
    #1;
    chk("t2.w_fire", int'(a_wf), 0);
    tick();
    chk("t2.ovf", int'(a_ov), 1);
    da(0, 0, 0, 0);
    repeat (3) begin
      tick();
      chk("t2.ovf_hold", int'(a_ov), 1);
    end
    da(0, 0, 0, 1);
    tick();
    chk("t2.ovf_clr", int'(a_ov), 0);

    // 3: simultaneous requests at full, then at empty
    da(1, 1, 0, 0);
    #1;
    chk("t3.r_fire_full", int'(a_rf), 1);
    chk("t3.w_fire_full", int'(a_wf), 0);
    tick();
    chk("t3.count7", int'(a_cnt), 7);
    chk("t3.full0", int'(a_full), 0);
    chk("t3.ovf", int'(a_ov), 1);
    da(0, 1, 0, 1);
    tick();
    da(0, 1, 0, 0);
    repeat (6) tick();
    chk("t3.empty", int'(a_empty), 1);
    da(1, 1, 0, 0);
    #1;
    chk("t3.w_fire_empty", int'(a_wf), 1);
    chk("t3.r_fire_empty", int'(a_rf), 0);
    tick();
    chk("t3.count1", int'(a_cnt), 1);
    chk("t3.unf", int'(a_un), 1);

    // 4: steady state at count 4 with both sides active
    da(1, 0, 0, 1);
    tick();
    da(1, 0, 0, 0);
    tick();
    tick();
    chk("t4.count_start", int'(a_cnt), 4);
    da(1, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4.count", int'(a_cnt), 4);
      chk("t4.gap", (int'(a_wa) - int'(a_ra) + 8) % 8, 4);
    end

    // 6a: flush at count 6 with a write pending
    da(1, 0, 0, 0);
    tick();
    tick();
    chk("t6.count6", int'(a_cnt), 6);
    da(1, 0, 1, 0);
    #1;
    chk("t6.w_fire_flush", int'(a_wf), 0);
    tick();
    chk("t6.count", int'(a_cnt), 0);
    chk("t6.w_addr", int'(a_wa), 0);
    chk("t6.r_addr", int'(a_ra), 0);
    chk("t6.empty", int'(a_empty), 1);

    // 6b: asynchronous reset mid-burst
    da(1, 0, 0, 0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.arst_count", int'(a_cnt), 0);
    chk("t6.arst_w_addr", int'(a_wa), 0);
    chk("t6.arst_w_fire", int'(a_wf), 0);
    chk("t6.arst_empty", int'(a_empty), 1);
    da(0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // 5: DEPTH=5 pointer sequence, full at 5, then random traffic
    for (int i = 0; i < 5; i++) begin
      db(1, 0, 0, 0);
      #1;
      chk("t5.w_addr", int'(b_wa), i);
      tick();
    end
    chk("t5.w_wrap", int'(b_wa), 0);
    chk("t5.full", int'(b_full), 1);
    chk("t5.count", int'(b_cnt), 5);
    for (int i = 0; i < 5; i++) begin
      db(0, 1, 0, 0);
      #1;
      chk("t5.r_addr", int'(b_ra), i);
      tick();
    end
    chk("t5.r_wrap", int'(b_ra), 0);
    chk("t5.empty", int'(b_empty), 1);
    for (int i = 0; i < 1000; i++) begin
      db(1'($urandom_range(1)), 1'($urandom_range(1)),
         ($urandom_range(15) == 0), ($urandom_range(7) == 0));
      tick();
    end
    db(0, 0, 0, 0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_flex.md
Name: fifo_ctrl_flex

Overview:
Next-generation FIFO control unit that drives a separate dual-port SRAM: it generates write/read addresses and qualified write/read strobes for the RAM. Generalises the fixed power-of-2 controller with:
- arbitrary DEPTH, including non-power-of-2, with explicit pointer wrap
- an occupancy count
- programmable almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- a synchronous flush

Sits between the producer/consumer handshake logic and the SRAM array in the FIFO subsystem.

Parameters:
- DEPTH, 8, number of entries; any integer >= 2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
- ADDR_WIDTH (localparam), $clog2(DEPTH), address width.
- CNT_WIDTH (localparam), $clog2(DEPTH+1), count width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- w_en  in  1  write request.
- r_en  in  1  read request.
- flush  in  1  synchronous flush; empties the FIFO.
- clr_err  in  1  synchronous clear of overflow/underflow.
- w_fire  out  1  write accepted this cycle (combinational); SRAM write enable.
- r_fire  out  1  read accepted this cycle (combinational); SRAM read enable.
- w_addr  out  ADDR_WIDTH  current write pointer (registered).
- r_addr  out  ADDR_WIDTH  current read pointer (registered).
- count  out  CNT_WIDTH  occupancy, 0..DEPTH (registered).
- full  out  1  count == DEPTH (registered).
- empty  out  1  count == 0 (registered).
- almost_full  out  1  count >= AF_LEVEL (registered).
- almost_empty  out  1  count <= AE_LEVEL (registered).
- overflow  out  1  sticky: a write was rejected because the FIFO was full.
- underflow  out  1  sticky: a read was rejected because the FIFO was empty.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pointers=0, count=0, empty=1, full=0, almost_empty=1 (AE_LEVEL>=0), almost_full=0, overflow=0, underflow=0.
  - w_fire and r_fire are forced 0 while rst_n=0.
  - Reset mid-operation discards all contents.
- Acceptance (combinational, from registered flags):
  - w_fire = w_en & ~full & ~flush.
  - r_fire = r_en & ~empty & ~flush.
- Pointer advance:
  - On fire, the pointer advances by 1. When the pointer equals DEPTH-1 it wraps to 0 (compare-and-wrap, not natural overflow).
  - Addresses update one cycle after the fire; the SRAM uses the pre-increment address.
- Count update: count_next = count + w_fire - r_fire.
  - Simultaneous accepted read and write: both pointers advance, count unchanged.
- Simultaneous requests at a boundary:
  - Full with w_en & r_en: read accepted, write rejected, overflow set, count drops to DEPTH-1.
  - Empty with w_en & r_en: write accepted, read rejected, underflow set, count becomes 1.
  - No write-through/bypass.
- Flags:
  - full, empty, almost_full and almost_empty are registered, decoded from count_next, so they are valid the same cycle count updates.
  - Latency from fire to flag change: 1 cycle.
- Error flags:
  - overflow set when w_en & full & ~flush; underflow set when r_en & empty & ~flush.
  - Both hold until clr_err=1 or reset.
  - If clr_err and a new error occur in the same cycle, set wins.
- Flush (priority over w_en/r_en):
  - Next cycle: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0.
  - Error flags are not affected.
- Width rules: count is never truncated; the pointer increment is computed at ADDR_WIDTH+1 bits before the wrap compare.

Decomposition:
- Package fifo_pkg holds:
  - the ptr_wrap function (increment-with-wrap for a given DEPTH);
  - a typedef struct fifo_status_t {full, empty, almost_full, almost_empty, overflow, underflow} for reuse by status registers.
- One sub-module is natural: fifo_ptr, a wrap counter instantiated twice (write and read).
  - Inputs: clk, rst_n, inc, clr.
  - Output: ptr.
- Count and flag logic stay in the top module.

Test Plan:
1. DEPTH=8, AF=6, AE=2. Reset, then 8 writes with no reads:
   - w_addr steps 0..7 then wraps to 0; count=8, full=1.
   - almost_full rises on the cycle count reaches 6; almost_empty falls when count reaches 3.
2. From full, a 9th write:
   - w_fire=0, overflow=1 and stays 1 through 3 idle cycles.
   - clr_err pulse clears overflow the next cycle.
3. From full, w_en=r_en=1 for 1 cycle:
   - r_fire=1, w_fire=0, count=7, full=0, overflow=1.
   - From empty, the same stimulus gives w_fire=1, r_fire=0, count=1, underflow=1.
4. Count=4, w_en=r_en=1 for 20 cycles:
   - count stays 4.
   - Both pointers wrap 7->0 repeatedly and stay 4 apart mod 8.
5. DEPTH=5, continuous writes/reads:
   - pointer sequence is 0,1,2,3,4,0.
   - full at count 5; flags match a reference model over 1000 random cycles.
6. Edge cases:
   - Flush at count=6 with w_en=1: next cycle pointers=0, count=0, empty=1, w_fire=0 during the flush.
   - rst_n driven low mid-burst asynchronously: outputs return to reset values before the next clock edge.
